id_operand_stage: RTL and testbench

- Decode-to-execute operand stage; sits directly downstream of the register file.
- Drives the register file read addresses from the decoded instruction.
- Forwards in-flight results from the EX and MEM stages.
- Detects load-use hazards and inserts bubbles. Holds the ID/EX pipeline register feeding the ALU.

---
 rtl/id_operand_stage.sv | 137 +++++++++++++
 tb/tb_id_operand_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: register-file addressing, EX/MEM forwarding,
// load-use bubble insertion and the ID/EX pipeline register feeding the ALU.
module id_operand_stage #(
    parameter int CTRL_W = 8,
    parameter int IMM_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic [4:0]        in_waddr,
    input  logic              in_wen,
    input  logic              in_is_load,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic [31:0]       ex_result,
    input  logic              mem_wen,
    input  logic [4:0]        mem_waddr,
    input  logic [31:0]       mem_wdata,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [31:0]       out_op1,
    output logic [31:0]       out_op2,
    output logic [4:0]        out_waddr,
    output logic              out_wen,
    output logic              out_is_load,
    output logic [IMM_W-1:0]  out_imm,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              valid_reg;
    logic              wen_reg;
    logic              is_load_reg;
    logic [4:0]        waddr_reg;
    logic [31:0]       op1_reg;
    logic [31:0]       op2_reg;
    logic [IMM_W-1:0]  imm_reg;
    logic [CTRL_W-1:0] ctrl_reg;

    logic [1:0][4:0]   src;
    logic [1:0]        use_src;
    logic [1:0][31:0]  rf_data;
    logic [1:0][31:0]  fwd_data;
    logic [1:0]        load_dep;
    logic              hazard;

    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;

    assign src[0]     = in_rs;
    assign src[1]     = in_rt;
    assign use_src[0] = in_use_rs;
    assign use_src[1] = in_use_rt;
    assign rf_data[0] = rf_rdata1;
    assign rf_data[1] = rf_rdata2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic ex_match;
            logic mem_match;

            assign ex_match  = valid_reg && wen_reg && (waddr_reg == src[gi]) && (src[gi] != 5'd0);
            assign mem_match = mem_wen && (mem_waddr == src[gi]) && (src[gi] != 5'd0);

            // A load in EX has no data yet; fall through to older results (the
            // hazard logic keeps such a pair from ever being captured).
            always_comb begin
                fwd_data[gi] = rf_data[gi];
                if (ex_match && !is_load_reg) begin
                    fwd_data[gi] = ex_result;
                end else if (mem_match) begin
                    fwd_data[gi] = mem_wdata;
                end
            end

            assign load_dep[gi] = use_src[gi] && (src[gi] == waddr_reg);
        end
    endgenerate

    assign hazard = valid_reg && is_load_reg && (waddr_reg != 5'd0) && in_valid && (|load_dep);

    // A flush discards the IF/ID instruction, so upstream may always advance.
    assign in_ready = flush || (!ex_stall && !hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            wen_reg     <= 1'b0;
            is_load_reg <= 1'b0;
            waddr_reg   <= '0;
            op1_reg     <= '0;
            op2_reg     <= '0;
            imm_reg     <= '0;
            ctrl_reg    <= '0;
        end else if (flush) begin
            valid_reg   <= 1'b0;
            wen_reg     <= 1'b0;
            is_load_reg <= 1'b0;
        end else if (ex_stall) begin
            // Hold everything; operands are deliberately not re-forwarded.
            valid_reg   <= valid_reg;
        end else if (hazard) begin
            valid_reg   <= 1'b0;
            wen_reg     <= 1'b0;
            is_load_reg <= 1'b0;
        end else begin
            valid_reg   <= in_valid;
            wen_reg     <= in_wen && in_valid;
            is_load_reg <= in_is_load && in_valid;
            waddr_reg   <= in_waddr;
            op1_reg     <= fwd_data[0];
            op2_reg     <= fwd_data[1];
            imm_reg     <= in_imm;
            ctrl_reg    <= in_ctrl;
        end
    end

    assign out_valid   = valid_reg;
    assign out_wen     = wen_reg;
    assign out_is_load = is_load_reg;
    assign out_waddr   = waddr_reg;
    assign out_op1     = op1_reg;
    assign out_op2     = op2_reg;
    assign out_imm     = imm_reg;
    assign out_ctrl    = ctrl_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding priority, load-use bubble,
// $0 guard, stall hold and flush behaviour.
module tb_id_operand_stage;

    localparam int CTRL_W = 8;
    localparam int IMM_W  = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic              in_use_rs;
    logic              in_use_rt;
    logic [4:0]        in_waddr;
    logic              in_wen;
    logic              in_is_load;
    logic [IMM_W-1:0]  in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        rf_raddr1;
    logic [4:0]        rf_raddr2;
    logic [31:0]       rf_rdata1;
    logic [31:0]       rf_rdata2;
    logic [31:0]       ex_result;
    logic              mem_wen;
    logic [4:0]        mem_waddr;
    logic [31:0]       mem_wdata;
    logic              ex_stall;
    logic              flush;
    logic              out_valid;
    logic [31:0]       out_op1;
    logic [31:0]       out_op2;
    logic [4:0]        out_waddr;
    logic              out_wen;
    logic              out_is_load;
    logic [IMM_W-1:0]  out_imm;
    logic [CTRL_W-1:0] out_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    id_operand_stage #(.CTRL_W(CTRL_W), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_waddr(in_waddr), .in_wen(in_wen), .in_is_load(in_is_load),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_result(ex_result),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ex_stall(ex_stall), .flush(flush),
        .out_valid(out_valid), .out_op1(out_op1), .out_op2(out_op2),
        .out_waddr(out_waddr), .out_wen(out_wen), .out_is_load(out_is_load),
        .out_imm(out_imm), .out_ctrl(out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] wa, input logic we, input logic ld);
        in_valid   = 1'b1;
        in_rs      = rs;
        in_use_rs  = urs;
        in_rt      = rt;
        in_use_rt  = urt;
        in_waddr   = wa;
        in_wen     = we;
        in_is_load = ld;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_rs = 0; in_rt = 0; in_use_rs = 0; in_use_rt = 0;
        in_waddr = 0; in_wen = 0; in_is_load = 0; in_imm = 0; in_ctrl = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; ex_result = 0;
        mem_wen = 0; mem_waddr = 0; mem_wdata = 0;
        ex_stall = 0; flush = 0;
        #2;
        step();
        rst = 1'b0;
        check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_op1", out_op1, 32'd0);
        check_eq("reset_op2", out_op2, 32'd0);
        check_eq("reset_wen", {31'd0, out_wen}, 32'd0);

        // EX forward: add $5 in EX, then a reader of $5.
        issue(5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
        step();
        check_eq("add5_valid", {31'd0, out_valid}, 32'd1);
        check_eq("add5_waddr", {27'd0, out_waddr}, 32'd5);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        ex_result = 32'h0000_0011;
        rf_rdata1 = 32'hDEAD_BEEF;
        #1;
        check_eq("ex_fwd_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rf_raddr1", {27'd0, rf_raddr1}, 32'd5);
        step();
        check_eq("ex_fwd_op1", out_op1, 32'h0000_0011);

        // EX beats MEM for $7; then MEM alone; then register file.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        step();
        issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        ex_result = 32'hAAAA_0000;
        mem_wen = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h0000_BBBB;
        rf_rdata2 = 32'h2222_2222;
        step();
        check_eq("ex_over_mem_op2", out_op2, 32'hAAAA_0000);
        step();
        check_eq("mem_fwd_op2", out_op2, 32'h0000_BBBB);
        mem_wen = 1'b0;
        step();
        check_eq("rf_op2", out_op2, 32'h2222_2222);

        // Load-use: lw $8 then a reader of $8 costs one bubble.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        check_eq("lw_is_load", {31'd0, out_is_load}, 32'd1);
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        ex_result = 32'h0000_0BAD;
        rf_rdata1 = 32'h0BAD_0BAD;
        #1;
        check_eq("lu_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        check_eq("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
        check_eq("lu_bubble_wen", {31'd0, out_wen}, 32'd0);
        mem_wen = 1'b1; mem_waddr = 5'd8; mem_wdata = 32'h1234_5678;
        #1;
        check_eq("lu_ready_high", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("lu_mem_op1", out_op1, 32'h1234_5678);
        check_eq("lu_valid", {31'd0, out_valid}, 32'd1);
        mem_wen = 1'b0;

        // $0 guard: lw writing $0 never stalls or forwards.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        step();
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        rf_rdata1 = 32'd0;
        ex_result = 32'hFFFF_FFFF;
        mem_wen = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'hFFFF_FFFF;
        #1;
        check_eq("r0_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("r0_op1", out_op1, 32'd0);
        mem_wen = 1'b0;

        // Stall holds everything for 3 cycles, then flush during the stall.
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        rf_rdata1 = 32'h0000_0033;
        in_imm = 32'h0000_1234;
        in_ctrl = 8'h5A;
        step();
        check_eq("pre_stall_op1", out_op1, 32'h0000_0033);
        check_eq("pre_stall_ctrl", {24'd0, out_ctrl}, 32'h5A);
        ex_stall = 1'b1;
        issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd12, 1'b0, 1'b0);
        rf_rdata1 = 32'h0000_0044;
        in_imm = 32'h0000_9999;
        in_ctrl = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("stall%0d_ready", i), {31'd0, in_ready}, 32'd0);
            step();
            check_eq($sformatf("stall%0d_op1", i), out_op1, 32'h0000_0033);
            check_eq($sformatf("stall%0d_imm", i), out_imm, 32'h0000_1234);
            check_eq($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check_eq($sformatf("stall%0d_waddr", i), {27'd0, out_waddr}, 32'd11);
        end
        flush = 1'b1;
        #1;
        check_eq("flush_stall_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_wen", {31'd0, out_wen}, 32'd0);
        flush = 1'b0;
        ex_stall = 1'b0;

        // Flush wins over a load-use hazard.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        step();
        issue(5'd0, 1'b0, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0);
        #1;
        check_eq("hz_ready_low", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        #1;
        check_eq("flush_hz_ready", {31'd0, in_ready}, 32'd1);
        step();
        check_eq("flush_hz_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_hz_load", {31'd0, out_is_load}, 32'd0);
        flush = 1'b0;

        // Idle input propagates a bubble.
        in_valid = 1'b0;
        step();
        check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
        check_eq("idle_wen", {31'd0, out_wen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
